// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: cache fill, CPU write and SDRAM controller signals of the port arbiter
interface sdram_port_arbiter_if;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic        cache_fill;
    logic [15:0] cache_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_bytesel;
    logic        wr_ack;
    logic        ctl_req;
    logic        ctl_rw;
    logic [31:0] ctl_addr;
    logic [15:0] ctl_wdata;
    logic [1:0]  ctl_bytesel;
    logic        ctl_ack;
    logic        ctl_fill;
    logic [15:0] ctl_rdata;
    logic        busy;
    modport master (
        input  cache_req, cache_addr, wr_req, wr_addr, wr_data, wr_bytesel, ctl_ack, ctl_fill, ctl_rdata,
        output cache_fill, cache_data, wr_ack, ctl_req, ctl_rw, ctl_addr, ctl_wdata, ctl_bytesel, busy
    );
    modport slave (
        output cache_req, cache_addr, wr_req, wr_addr, wr_data, wr_bytesel, ctl_ack, ctl_fill, ctl_rdata,
        input  cache_fill, cache_data, wr_ack, ctl_req, ctl_rw, ctl_addr, ctl_wdata, ctl_bytesel, busy
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one 16-bit SDRAM controller port between 8-halfword cache fills and split 32-bit CPU writes
module sdram_port_arbiter (
    input logic clk,
    input logic reset,
    sdram_port_arbiter_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_BURST = 3'd2, WR_HI = 3'd3,
                           WR_LO = 3'd4, WR_DONE = 3'd5, WR_WAIT = 3'd6;
    logic [2:0]  state;
    logic [2:0]  fill_cnt;
    logic        last_grant;
    logic [15:0] lo_data;
    logic [1:0]  lo_sel;
    logic        acked, grant_rd, grant_wr, fill_en;
    assign acked    = bus.ctl_req & bus.ctl_ack;
    // last_grant high means the previous grant went to the write side
    assign grant_rd = bus.cache_req & (~bus.wr_req | last_grant);
    assign grant_wr = bus.wr_req & ~grant_rd;
    assign fill_en  = bus.ctl_fill & (state == RD_BURST | (state == RD_REQ & acked));
    assign bus.cache_fill = bus.ctl_fill & (state == RD_REQ | state == RD_BURST);
    assign bus.cache_data = bus.ctl_rdata;
    assign bus.busy       = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            fill_cnt        <= 3'd0;
            last_grant      <= 1'b1;
            lo_data         <= 16'd0;
            lo_sel          <= 2'd0;
            bus.ctl_req     <= 1'b0;
            bus.ctl_rw      <= 1'b1;
            bus.ctl_addr    <= 32'd0;
            bus.ctl_wdata   <= 16'd0;
            bus.ctl_bytesel <= 2'd0;
            bus.wr_ack      <= 1'b0;
        end else begin
            bus.wr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        state        <= RD_REQ;
                        last_grant   <= 1'b0;
                        fill_cnt     <= 3'd0;
                        bus.ctl_rw   <= 1'b1;
                        bus.ctl_addr <= {bus.cache_addr[31:2], 2'b00};
                    end else if (grant_wr) begin
                        last_grant <= 1'b1;
                        bus.ctl_rw <= 1'b0;
                        lo_data    <= bus.wr_data[15:0];
                        lo_sel     <= bus.wr_bytesel[1:0];
                        if (|bus.wr_bytesel[3:2]) begin
                            state           <= WR_HI;
                            bus.ctl_addr    <= {bus.wr_addr[31:2], 2'b00};
                            bus.ctl_wdata   <= bus.wr_data[31:16];
                            bus.ctl_bytesel <= bus.wr_bytesel[3:2];
                        end else if (|bus.wr_bytesel[1:0]) begin
                            state           <= WR_LO;
                            bus.ctl_addr    <= {bus.wr_addr[31:2], 2'b10};
                            bus.ctl_wdata   <= bus.wr_data[15:0];
                            bus.ctl_bytesel <= bus.wr_bytesel[1:0];
                        end else begin
                            state      <= WR_DONE;
                            bus.wr_ack <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    bus.ctl_req <= ~acked;
                    if (acked) state <= RD_BURST;
                end
                WR_HI: begin
                    bus.ctl_req <= ~acked;
                    if (acked && |lo_sel) begin
                        state           <= WR_LO;
                        bus.ctl_addr    <= {bus.ctl_addr[31:2], 2'b10};
                        bus.ctl_wdata   <= lo_data;
                        bus.ctl_bytesel <= lo_sel;
                    end else if (acked) begin
                        state      <= WR_DONE;
                        bus.wr_ack <= 1'b1;
                    end
                end
                WR_LO: begin
                    bus.ctl_req <= ~acked;
                    if (acked) begin
                        state      <= WR_DONE;
                        bus.wr_ack <= 1'b1;
                    end
                end
                WR_DONE: state <= WR_WAIT;
                WR_WAIT: if (!bus.wr_req) state <= IDLE;
                RD_BURST: ;
                default: state <= IDLE;
            endcase
            // the burst ends on the eighth forwarded halfword regardless of cache_req
            if (fill_en) begin
                fill_cnt <= fill_cnt + 3'd1;
                if (fill_cnt == 3'd7) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed checks of read bursts, split writes, tie arbitration and mid-burst reset
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    sdram_port_arbiter_if bus ();
    sdram_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !bus.ctl_req; i++) tick();
        chk(tag, {31'd0, bus.ctl_req}, 32'd1);
    endtask
    task automatic ack(input string tag);
        bus.ctl_ack = 1'b1;
        tick();
        bus.ctl_ack = 1'b0;
        chk(tag, {31'd0, bus.ctl_req}, 32'd0);
    endtask
    task automatic fill8(input logic [15:0] base, input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.ctl_fill  = 1'b1;
            bus.ctl_rdata = base + 16'(i);
            if (i == 0) bus.cache_req = 1'b0;
            #1;
            chk({tag, "_fill"}, {31'd0, bus.cache_fill}, 32'd1);
            chk({tag, "_data"}, {16'd0, bus.cache_data}, {16'd0, base + 16'(i)});
            tick();
        end
        bus.ctl_fill = 1'b0;
        chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n;
        reset = 1'b1;
        bus.cache_req = 0; bus.cache_addr = 0; bus.wr_req = 0; bus.wr_addr = 0;
        bus.wr_data = 0; bus.wr_bytesel = 0; bus.ctl_ack = 0; bus.ctl_fill = 1; bus.ctl_rdata = 16'h5555;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_req", {31'd0, bus.ctl_req}, 32'd0);
        chk("rst_rw", {31'd0, bus.ctl_rw}, 32'd1);
        chk("rst_addr", bus.ctl_addr, 32'd0);
        chk("rst_wdata", {16'd0, bus.ctl_wdata}, 32'd0);
        chk("rst_sel", {30'd0, bus.ctl_bytesel}, 32'd0);
        chk("rst_wrack", {31'd0, bus.wr_ack}, 32'd0);
        chk("rst_cfill", {31'd0, bus.cache_fill}, 32'd0);
        reset = 1'b0;
        bus.ctl_fill = 1'b0;
        tick();
        // read miss with exact request latency and ack two cycles into the request
        bus.cache_req = 1; bus.cache_addr = 32'h0000_1238;
        tick();
        chk("rd_busy", {31'd0, bus.busy}, 32'd1);
        chk("rd_req_lat", {31'd0, bus.ctl_req}, 32'd0);
        tick();
        chk("rd_req", {31'd0, bus.ctl_req}, 32'd1);
        chk("rd_rw", {31'd0, bus.ctl_rw}, 32'd1);
        chk("rd_addr", bus.ctl_addr, 32'h0000_1238);
        tick();
        chk("rd_req_held", {31'd0, bus.ctl_req}, 32'd1);
        ack("rd_req_drop");
        chk("rd_busy_burst", {31'd0, bus.busy}, 32'd1);
        fill8(16'hA000, "rd");
        bus.ctl_fill = 1'b1;
        #1;
        chk("stray_fill", {31'd0, bus.cache_fill}, 32'd0);
        tick();
        bus.ctl_fill = 1'b0;
        // full 32-bit write
        bus.wr_req = 1; bus.wr_addr = 32'h100; bus.wr_data = 32'h1122_3344; bus.wr_bytesel = 4'hF;
        tick();
        tick();
        chk("fw_req_hi", {31'd0, bus.ctl_req}, 32'd1);
        chk("fw_rw", {31'd0, bus.ctl_rw}, 32'd0);
        chk("fw_addr_hi", bus.ctl_addr, 32'h100);
        chk("fw_data_hi", {16'd0, bus.ctl_wdata}, 32'h1122);
        chk("fw_sel_hi", {30'd0, bus.ctl_bytesel}, 32'd3);
        ack("fw_req_drop_hi");
        chk("fw_ack_early", {31'd0, bus.wr_ack}, 32'd0);
        tick();
        chk("fw_req_lo", {31'd0, bus.ctl_req}, 32'd1);
        chk("fw_addr_lo", bus.ctl_addr, 32'h102);
        chk("fw_data_lo", {16'd0, bus.ctl_wdata}, 32'h3344);
        chk("fw_sel_lo", {30'd0, bus.ctl_bytesel}, 32'd3);
        ack("fw_req_drop_lo");
        chk("fw_wrack", {31'd0, bus.wr_ack}, 32'd1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n += int'(bus.ctl_req) + int'(bus.wr_ack);
        end
        chk("fw_no_repeat", n, 32'd0);
        chk("fw_wait_busy", {31'd0, bus.busy}, 32'd1);
        bus.wr_req = 0;
        tick();
        chk("fw_idle", {31'd0, bus.busy}, 32'd0);
        // low-halfword-only write
        bus.wr_req = 1; bus.wr_bytesel = 4'h2;
        tick();
        tick();
        chk("pw_req", {31'd0, bus.ctl_req}, 32'd1);
        chk("pw_addr", bus.ctl_addr, 32'h102);
        chk("pw_data", {16'd0, bus.ctl_wdata}, 32'h3344);
        chk("pw_sel", {30'd0, bus.ctl_bytesel}, 32'd2);
        ack("pw_req_drop");
        chk("pw_wrack", {31'd0, bus.wr_ack}, 32'd1);
        bus.wr_req = 0;
        tick();
        chk("pw_wrack_pulse", {31'd0, bus.wr_ack}, 32'd0);
        tick();
        chk("pw_idle", {31'd0, bus.busy}, 32'd0);
        // empty byte mask completes without touching the controller
        bus.wr_req = 1; bus.wr_bytesel = 4'h0;
        tick();
        chk("zw_wrack", {31'd0, bus.wr_ack}, 32'd1);
        chk("zw_noreq", {31'd0, bus.ctl_req}, 32'd0);
        bus.wr_req = 0;
        tick();
        chk("zw_noreq2", {31'd0, bus.ctl_req}, 32'd0);
        tick();
        chk("zw_idle", {31'd0, bus.busy}, 32'd0);
        // tie after reset: read first, then write, then read again
        reset = 1;
        tick();
        reset = 0;
        bus.cache_req = 1; bus.cache_addr = 32'h2000;
        bus.wr_req = 1; bus.wr_bytesel = 4'hF;
        tick();
        tick();
        chk("tie1_rw", {31'd0, bus.ctl_rw}, 32'd1);
        chk("tie1_addr", bus.ctl_addr, 32'h2000);
        ack("tie1_ack");
        fill8(16'hC000, "tie1");
        wait_req("tie_wr_req");
        chk("tie_wr_rw", {31'd0, bus.ctl_rw}, 32'd0);
        chk("tie_wr_addr", bus.ctl_addr, 32'h100);
        ack("tie_wr_ack_hi");
        wait_req("tie_wr_req_lo");
        chk("tie_wr_addr_lo", bus.ctl_addr, 32'h102);
        ack("tie_wr_ack_lo");
        chk("tie_wrack", {31'd0, bus.wr_ack}, 32'd1);
        bus.wr_req = 0;
        tick();
        tick();
        chk("tie_idle", {31'd0, bus.busy}, 32'd0);
        bus.cache_req = 1; bus.cache_addr = 32'h3000; bus.wr_req = 1;
        tick();
        tick();
        chk("tie2_req", {31'd0, bus.ctl_req}, 32'd1);
        chk("tie2_rw", {31'd0, bus.ctl_rw}, 32'd1);
        chk("tie2_addr", bus.ctl_addr, 32'h3000);
        // reset on the third fill of this burst
        ack("tie2_ack");
        for (int i = 0; i < 3; i++) begin
            bus.ctl_fill = 1; bus.ctl_rdata = 16'hD000 + 16'(i);
            if (i == 2) reset = 1;
            tick();
        end
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_cfill", {31'd0, bus.cache_fill}, 32'd0);
        bus.cache_req = 0; bus.wr_req = 0; reset = 0;
        tick();
        chk("mid_rst_resid", {31'd0, bus.cache_fill}, 32'd0);
        bus.ctl_fill = 0;
        bus.cache_req = 1; bus.cache_addr = 32'h4000;
        tick();
        wait_req("post_rst_req");
        chk("post_rst_addr", bus.ctl_addr, 32'h4000);
        chk("post_rst_rw", {31'd0, bus.ctl_rw}, 32'd1);
        ack("post_rst_ack");
        fill8(16'hB000, "post_rst");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
